// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO reader.
package fifo_reader_pkg;

    localparam int unsigned DataWidthDefault = 32;
    localparam int unsigned CntWidthDefault  = 16;

    // Output buffer occupancy; the encoding equals the number of held words.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    // Number of words held in a given occupancy state.
    function automatic logic [1:0] occ_count(occ_e occ);
        case (occ)
            OccOne:  return 2'd1;
            OccTwo:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and consumer-side handshake bundle for the FIFO reader.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDefault
);

    // FIFO side
    logic                  queue_empty;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] read_data;

    // Consumer side
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  queue_empty,
        output read_en,
        input  read_data,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        output queue_empty,
        input  read_en,
        output read_data,
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry register pair (head, tail) with shift-on-pop; occupancy is tracked by the parent.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic                  wr_en,
    input  logic                  wr_tail,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    // Shift tail forward on pop; a head write overrides the shift (capture+pop in ONE).
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (shift) begin
            head_d = tail_q;
        end
        if (wr_en) begin
            if (wr_tail) begin
                tail_d = wr_data;
            end else begin
                head_d = wr_data;
            end
        end
    end

    // Storage registers, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Reads a registered-output FIFO into a 2-entry buffer and presents a valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDefault,
    parameter int unsigned CNT_WIDTH  = CntWidthDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fifo_reader_if.master        bus,
    output logic [CNT_WIDTH-1:0] delivered_cnt
);

    occ_e                  occ_q, occ_d;
    logic                  inflight_q;
    logic                  run_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  pop;
    logic                  capture;
    logic                  wr_tail;
    logic                  read_en;
    logic [2:0]            pending;
    logic [DATA_WIDTH-1:0] head_data;

    // Read issue, capture steering and occupancy next-state.
    always_comb begin
        pop     = (occ_q != OccEmpty) & bus.out_ready;
        // Words held or due, minus the one leaving this cycle; never exceeds 2.
        pending = {1'b0, occ_count(occ_q)} + {2'b0, inflight_q} - {2'b0, pop};
        read_en = run_q & !bus.queue_empty & !flush & (pending < 3'd2);
        capture = inflight_q & !flush;
        // Only a capture in ONE without a pop lands behind the head.
        wr_tail = (occ_q == OccOne) & !pop;
        cnt_d   = cnt_q + CNT_WIDTH'(pop);

        occ_d = occ_q;
        if (flush) begin
            occ_d = OccEmpty;
        end else begin
            unique case (occ_q)
                OccEmpty: occ_d = capture ? OccOne : OccEmpty;
                OccOne: begin
                    if (capture && !pop) begin
                        occ_d = OccTwo;
                    end else if (!capture && pop) begin
                        occ_d = OccEmpty;
                    end else begin
                        occ_d = OccOne;
                    end
                end
                OccTwo:   occ_d = pop ? OccOne : OccTwo;
                default:  occ_d = OccEmpty;
            endcase
        end
    end

    // Occupancy, in-flight flag and delivered counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= OccEmpty;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= read_en;
            cnt_q      <= cnt_d;
        end
    end

    // Holds off reads until the first rising edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .shift     (pop),
        .wr_en     (capture),
        .wr_tail   (wr_tail),
        .wr_data   (bus.read_data),
        .head_data (head_data)
    );

    assign bus.read_en   = read_en;
    assign bus.out_valid = (occ_q != OccEmpty);
    assign bus.out_data  = head_data;
    assign delivered_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a one-cycle-latency FIFO source model.
module tb_fifo_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] delivered_cnt;

    fifo_reader_if #(.DATA_WIDTH(32)) bus ();

    fifo_reader #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .delivered_cnt (delivered_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] src_q[$];
    logic        stream_on;
    logic [31:0] stream_word;
    int          cyc;
    int          reads;
    int          underflows;

    int          first_re, first_ov, n_got, unstable, re_seen, ov_seen, beef_seen;
    int          pops, order_err, done;
    logic [31:0] got[3];
    int          got_cyc[3];

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: FIFO pops on the edge where read_en is seen, data valid 1 time unit later.
    task automatic cycle();
        logic re;
        re = bus.read_en;
        if (re && bus.queue_empty) underflows++;
        @(posedge clk);
        #1;
        if (re) begin
            reads++;
            if (stream_on) begin
                bus.read_data = stream_word;
                stream_word++;
            end else if (src_q.size() > 0) begin
                bus.read_data = src_q.pop_front();
            end else begin
                bus.read_data = 32'hDEAD_0000;
            end
            if (!stream_on) bus.queue_empty = (src_q.size() == 0);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        flush           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.queue_empty = 1'b1;
        bus.read_data   = '0;
        src_q.delete();
        stream_on       = 1'b0;
        stream_word     = '0;
        reads           = 0;
        underflows      = 0;
        cyc             = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state, with a non-empty queue to prove read_en is held off
        do_reset();
        src_q = '{32'hA0, 32'hA1, 32'hA2};
        bus.queue_empty = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_read_en", 32'(bus.read_en), 32'd0);
        check_eq("rst_cnt", 32'(delivered_cnt), 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        @(negedge clk);

        // Streaming three words, latency and order
        bus.out_ready = 1'b1;
        rst = 1'b1;
        first_re = -1;
        first_ov = -1;
        n_got = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.read_en && first_re < 0) first_re = cyc;
            if (bus.out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (n_got < 3) begin
                    got[n_got]     = bus.out_data;
                    got_cyc[n_got] = cyc;
                end
                n_got++;
            end
            cycle();
        end
        check_eq("stream_latency", 32'(first_ov - first_re), 32'd2);
        check_eq("stream_w0", got[0], 32'hA0);
        check_eq("stream_w1", got[1], 32'hA1);
        check_eq("stream_w2", got[2], 32'hA2);
        check_eq("stream_back_to_back", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        check_eq("stream_n_words", 32'(n_got), 32'd3);
        check_eq("stream_cnt", 32'(delivered_cnt), 32'd3);
        check_eq("stream_reads", 32'(reads), 32'd3);
        check_eq("stream_underflow", 32'(underflows), 32'd0);

        // Backpressure: exactly two reads, head stable
        do_reset();
        src_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        bus.queue_empty = 1'b0;
        rst = 1'b1;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid && bus.out_data !== 32'hB0) unstable++;
            cycle();
        end
        check_eq("bp_reads", 32'(reads), 32'd2);
        check_eq("bp_read_en", 32'(bus.read_en), 32'd0);
        check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("bp_head", bus.out_data, 32'hB0);
        check_eq("bp_unstable", 32'(unstable), 32'd0);
        check_eq("bp_cnt", 32'(delivered_cnt), 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check_eq("bp_next_head", bus.out_data, 32'hB1);
        check_eq("bp_cnt_one", 32'(delivered_cnt), 32'd1);
        cycle();
        cycle();
        check_eq("bp_full_valid", 32'(bus.out_valid), 32'd1);

        // Asynchronous reset between edges with two words buffered
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_read_en", 32'(bus.read_en), 32'd0);
        check_eq("arst_cnt", 32'(delivered_cnt), 32'd0);
        check_eq("arst_out_data", bus.out_data, 32'd0);
        @(negedge clk);

        // Empty queue throughout
        do_reset();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        re_seen = 0;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.read_en) re_seen++;
            if (bus.out_valid) ov_seen++;
            cycle();
        end
        check_eq("empty_read_en", 32'(re_seen), 32'd0);
        check_eq("empty_out_valid", 32'(ov_seen), 32'd0);

        // Flush with ONE buffered and 0xBEEF in flight; the pop that cycle still counts
        do_reset();
        src_q = '{32'h11, 32'hBEEF};
        bus.queue_empty = 1'b0;
        rst = 1'b1;
        repeat (3) cycle();
        check_eq("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        check_eq("flush_pre_head", bus.out_data, 32'h11);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("flush_read_en", 32'(bus.read_en), 32'd0);
        @(negedge clk);
        cycle();
        flush = 1'b0;
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_cnt", 32'(delivered_cnt), 32'd1);
        beef_seen = 0;
        ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) ov_seen++;
            if (bus.out_valid && bus.out_data == 32'hBEEF) beef_seen++;
            cycle();
        end
        check_eq("flush_beef_seen", 32'(beef_seen), 32'd0);
        check_eq("flush_valid_after", 32'(ov_seen), 32'd0);

        // Counter wrap: stream up to 0xFFFF pops, then two more
        do_reset();
        stream_on = 1'b1;
        bus.queue_empty = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        pops = 0;
        order_err = 0;
        done = 0;
        for (int i = 0; i < 70000; i++) begin
            if (pops == 65535) begin
                done = 1;
                break;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_data !== 32'(pops)) order_err++;
                pops++;
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        check_eq("wrap_reached", 32'(done), 32'd1);
        check_eq("wrap_order", 32'(order_err), 32'd0);
        check_eq("wrap_cnt_max", 32'(delivered_cnt), 32'hFFFF);
        repeat (3) cycle();
        stream_on = 1'b0;
        bus.queue_empty = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        bus.out_ready = 1'b0;
        check_eq("wrap_cnt", 32'(delivered_cnt), 32'h0001);
        check_eq("wrap_drained", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
